// File: rtl/byte_serial_adder.sv
// Multi-byte adder controller that drives an external 8-bit byte adder, LSB byte first.
// Optional subtract mode is enabled by defining BYTE_SERIAL_SUB_EN (adds the 'sub' port).
module byte_serial_adder #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   a_in,
   input  logic [8*NBYTES-1:0]   b_in,
   input  logic                  cin,
`ifdef BYTE_SERIAL_SUB_EN
   input  logic                  sub,
`endif
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout,
   output logic [7:0]            add_a,
   output logic [7:0]            add_b,
   output logic                  add_c,
   input  logic [7:0]            add_s,
   input  logic                  add_co,
   output logic [1:0]            dbg_state
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Handshake: start is sampled only in IDLE; busy covers the RUN cycles and
   // done pulses once when sum/cout are valid. There is no backpressure.
   state_t                   r_state;
   logic [NBYTES-1:0][7:0]   r_a;
   logic [NBYTES-1:0][7:0]   r_b;
   logic [NBYTES-1:0][7:0]   r_sum;
   logic [IW-1:0]            r_idx;
   logic                     r_carry;
   logic                     r_cout;
   logic                     r_busy;
   logic                     r_done;

   logic [8*NBYTES-1:0]      w_b_load;
   logic                     w_c_load;

`ifdef BYTE_SERIAL_SUB_EN
   // Subtract as A + ~B + 1; cout=1 then means no borrow.
   assign w_b_load = sub ? ~b_in : b_in;
   assign w_c_load = sub ? 1'b1 : cin;
`else
   assign w_b_load = b_in;
   assign w_c_load = cin;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a_in;
                  r_b     <= w_b_load;
                  r_carry <= w_c_load;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum[r_idx] <= add_s;
               r_carry      <= add_co;
               r_idx        <= r_idx + 1'b1;
               if (r_idx == IW'(NBYTES - 1)) begin
                  r_cout  <= add_co;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Carry into the byte adder comes only from the registered carry.
   assign add_a     = (r_state == S_RUN) ? r_a[r_idx] : 8'h00;
   assign add_b     = (r_state == S_RUN) ? r_b[r_idx] : 8'h00;
   assign add_c     = (r_state == S_RUN) ? r_carry    : 1'b0;

   assign busy      = r_busy;
   assign done      = r_done;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed bench for byte_serial_adder (NBYTES=4) with a behavioural 8-bit byte adder.
module tb_byte_serial_adder;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          cin;
  logic          sub_i;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_c;
  logic [7:0]    add_s;
  logic          add_co;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
`ifdef BYTE_SERIAL_SUB_EN
    .sub       (sub_i),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .add_s     (add_s),
    .add_co    (add_co),
    .dbg_state (dbg_state)
  );

  // External combinational byte adder
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_c};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // One full operation; b_adj is the B value the byte adder should see.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] b_adj, input logic c, input logic sv,
                        input logic glitch, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input logic [NB-1:0] exp_addc);
    logic [NB-1:0] addc_obs;
    addc_obs = '0;
    a_in = a; b_in = b; cin = c; sub_i = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      check({tag, " done_low"}, 64'(done), 64'd0);
      check({tag, " add_a"}, 64'(add_a), 64'(a[8*k +: 8]));
      check({tag, " add_b"}, 64'(add_b), 64'(b_adj[8*k +: 8]));
      addc_obs[k] = add_c;
      if (glitch && k == 1) begin
        start = 1'b1; a_in = 32'hDEADBEEF; b_in = 32'hCAFEF00D; cin = 1'b1;
      end
      if (glitch && k == 2) start = 1'b0;
      @(negedge clk);
    end
    check({tag, " add_c_seq"}, 64'(addc_obs), 64'(exp_addc));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy_in_done"}, 64'(busy), 64'd0);
    check({tag, " state_done"}, 64'(dbg_state), 64'd2);
    check({tag, " sum"}, 64'(sum), 64'(exp_sum));
    check({tag, " cout"}, 64'(cout), 64'(exp_cout));
    check({tag, " add_a_idle"}, 64'(add_a), 64'd0);
    @(negedge clk);
    check({tag, " done_pulse_end"}, 64'(done), 64'd0);
    check({tag, " state_idle"}, 64'(dbg_state), 64'd0);
    check({tag, " sum_hold"}, 64'(sum), 64'(exp_sum));
  endtask

  initial begin
    int t_first;
    int t_second;
    int n_done;

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst sum", 64'(sum), 64'd0);
    check("rst cout", 64'(cout), 64'd0);
    check("rst add_a", 64'(add_a), 64'd0);
    check("rst add_c", 64'(add_c), 64'd0);
    check("rst state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add1", 32'h12345678, 32'h11111111, 32'h11111111, 1'b0, 1'b0, 1'b0,
           32'h23456789, 1'b0, 4'b0000);
    run_op("ovf", 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0,
           32'h00000000, 1'b1, 4'b1110);
    run_op("cin", 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0,
           32'h00000001, 1'b0, 4'b0001);

    // start held high: operands changed while busy are picked up only by the next op
    t_first = -1; t_second = -1;
    a_in = 32'h00000002; b_in = 32'h00000003; cin = 1'b0; start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_in = 32'h00000010; b_in = 32'h00000020;
      end
      if (done && t_first < 0) begin
        t_first = n;
        check("held sum1", 64'(sum), 64'h5);
      end else if (done && t_second < 0) begin
        t_second = n;
        start = 1'b0;
        check("held sum2", 64'(sum), 64'h30);
      end
      if (t_second >= 0) break;
    end
    check("held first_latency", 64'(t_first), 64'd5);
    check("held period", 64'(t_second - t_first), 64'd6);
    @(negedge clk);
    check("held back_idle", 64'(dbg_state), 64'd0);

    // start pulse during RUN is ignored
    run_op("glitch", 32'h12345678, 32'h11111111, 32'h11111111, 1'b0, 1'b0, 1'b1,
           32'h23456789, 1'b0, 4'b0000);
    n_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("glitch extra_done", 64'(n_done), 64'd0);
    check("glitch stay_idle", 64'(busy), 64'd0);

    // reset in the second RUN cycle aborts
    a_in = 32'hFFFFFFFF; b_in = 32'h00000001; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort sum", 64'(sum), 64'd0);
    check("abort cout", 64'(cout), 64'd0);
    check("abort add_c", 64'(add_c), 64'd0);
    check("abort state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort no_done", 64'(n_done), 64'd0);
    check("abort sum_kept0", 64'(sum), 64'd0);
    run_op("after_rst", 32'h12345678, 32'h11111111, 32'h11111111, 1'b0, 1'b0, 1'b0,
           32'h23456789, 1'b0, 4'b0000);

`ifdef BYTE_SERIAL_SUB_EN
    run_op("sub_neg", 32'h00000005, 32'h00000007, 32'hFFFFFFF8, 1'b0, 1'b1, 1'b0,
           32'hFFFFFFFE, 1'b0, 4'b0001);
    run_op("sub_pos", 32'h00000007, 32'h00000005, 32'hFFFFFFFA, 1'b0, 1'b1, 1'b0,
           32'h00000002, 1'b1, 4'b1111);
    run_op("sub_off", 32'h12345678, 32'h11111111, 32'h11111111, 1'b0, 1'b0, 1'b0,
           32'h23456789, 1'b0, 4'b0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
